// File: rtl/bcd_seq_conv_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Imported by the adjust cell and the converter top.
package bcd_pkg;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_t;

endpackage

// File: rtl/bcd_seq_conv_if.sv
// Valid/ready bundle for bcd_seq_conv: binary word in, packed BCD out.
// Optional out_ovf signal exists only when BCD_SEQ_OVF_EN is defined.
interface bcd_seq_conv_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);

    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
`ifdef BCD_SEQ_OVF_EN
    logic                  out_ovf;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_bcd, out_ovf
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_bcd, out_ovf
    );
`else
    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_bcd
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_bcd
    );
`endif

endinterface

// File: rtl/bcd_seq_conv_digit_adj.sv
// Double-dabble add-3 cell: one BCD digit, corrected when it is 5 or more
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);

    assign q = (d >= BCD_ADJ_THRESH) ? d + BCD_ADJ_ADD : d;

endmodule

// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter, one shift per clock (double dabble).
// Define BCD_SEQ_OVF_EN to get a sticky out_ovf flag for truncated results.
module bcd_seq_conv
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    bcd_seq_conv_if.slave bus
);

    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    bcd_state_t      state;
    bcd_state_t      state_n;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] bin;
    logic [BW-1:0]   acc;
    logic [BW-1:0]   adj;
    logic            last_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign last_shift = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  state_n = SHIFT;
            SHIFT:   if (last_shift)    state_n = DONE;
            DONE:    if (bus.out_ready) state_n = IDLE;
            default:                    state_n = IDLE;
        endcase
    end

    // Adjusted digits shift up; the top bit of the last digit falls off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            bin   <= '0;
            acc   <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.in_valid) begin
                bin <= bus.in_bin;
                acc <= '0;
                cnt <= '0;
            end else if (state == SHIFT) begin
                acc <= {adj[BW-2:0], bin[WIDTH-1]};
                bin <= bin << 1;
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef BCD_SEQ_OVF_EN
    logic ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            ovf <= 1'b0;
        end else if (state == SHIFT && adj[BW-1]) begin
            ovf <= 1'b1;
        end
    end

    assign bus.out_ovf = ovf;
`endif

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_bcd   = acc;

endmodule
